// File: rtl/mips_hazard_pkg.sv
// mips_hazard_pkg: shared select encodings, FSM states and pipeline slot type
// for the forward/hazard unit.
package mips_hazard_pkg;
   localparam int NREG_BITS = 5;
   localparam logic [1:0] FWD_REGFILE = 2'd0;
   localparam logic [1:0] FWD_MEMWB   = 2'd1;
   localparam logic [1:0] FWD_EXMEM   = 2'd2;
   typedef enum logic {HZ_RUN, HZ_STALL} hz_state_t;
   typedef struct packed {
      logic [NREG_BITS-1:0] rs;
      logic [NREG_BITS-1:0] rt;
      logic [NREG_BITS-1:0] dest;
      logic                 regwrite;
      logic                 memread;
   } slot_t;
endpackage

// File: rtl/forward_hazard_unit_if.sv
// forward_hazard_unit_if: ID-stage inputs and EX-mux/hazard outputs of the unit.
// HAZARD_STATS_EN adds the stall/flush statistic counters.
interface forward_hazard_unit_if;
   import mips_hazard_pkg::*;
   logic [NREG_BITS-1:0] ID_Rs;
   logic [NREG_BITS-1:0] ID_Rt;
   logic [NREG_BITS-1:0] ID_Dest;
   logic                 ID_RegWrite;
   logic                 ID_MemRead;
   logic                 Branch_Taken;
   logic [1:0]           Forward_A;
   logic [1:0]           Forward_B;
   logic                 Stall;
   logic                 Bubble;
   logic                 Flush;
`ifdef HAZARD_STATS_EN
   logic [31:0]          Stall_Count;
   logic [31:0]          Flush_Count;
   modport master (output ID_Rs, ID_Rt, ID_Dest, ID_RegWrite, ID_MemRead, Branch_Taken,
                   input Forward_A, Forward_B, Stall, Bubble, Flush, Stall_Count, Flush_Count);
   modport slave (input ID_Rs, ID_Rt, ID_Dest, ID_RegWrite, ID_MemRead, Branch_Taken,
                  output Forward_A, Forward_B, Stall, Bubble, Flush, Stall_Count, Flush_Count);
`else
   modport master (output ID_Rs, ID_Rt, ID_Dest, ID_RegWrite, ID_MemRead, Branch_Taken,
                   input Forward_A, Forward_B, Stall, Bubble, Flush);
   modport slave (input ID_Rs, ID_Rt, ID_Dest, ID_RegWrite, ID_MemRead, Branch_Taken,
                  output Forward_A, Forward_B, Stall, Bubble, Flush);
`endif
endinterface

// File: rtl/forward_select.sv
// forward_select: picks the EX operand source for one source register from the
// MEM and WB slots; the nearer (MEM) producer wins, $0 is never forwarded.
module forward_select
   import mips_hazard_pkg::*;
(
   input  logic [NREG_BITS-1:0] src,
   input  slot_t                mem,
   input  slot_t                wb,
   output logic [1:0]           sel
);
   logic unused_fields;
   assign unused_fields = ^{mem.rs, mem.rt, mem.memread, wb.rs, wb.rt, wb.memread};
   assign sel = (mem.regwrite && mem.dest == src && mem.dest != '0) ? FWD_EXMEM
              : (wb.regwrite && wb.dest == src && wb.dest != '0)    ? FWD_MEMWB
              : FWD_REGFILE;
endmodule

// File: rtl/forward_hazard_unit.sv
// forward_hazard_unit: EX operand forwarding selects, load-use stall/bubble and
// branch flush. HAZARD_STATS_EN adds 32-bit stall/flush cycle counters.
module forward_hazard_unit
   import mips_hazard_pkg::*;
#(
   parameter int LOAD_USE_BUBBLES = 1
)(
   input  logic                  clk,
   input  logic                  reset,
   forward_hazard_unit_if.slave  hz
);
   localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_BUBBLES - 1);
   slot_t     ex, mem, wb;
   hz_state_t state;
   logic [1:0] cnt;
   logic       hit, bt;
   forward_select u_sel_a (.src(ex.rs), .mem(mem), .wb(wb), .sel(hz.Forward_A));
   forward_select u_sel_b (.src(ex.rt), .mem(mem), .wb(wb), .sel(hz.Forward_B));
   // Mealy hazard outputs; a taken branch always overrides a stall
   assign bt        = hz.Branch_Taken && reset;
   assign hit       = ex.memread && ex.dest != '0 && (ex.dest == hz.ID_Rs || ex.dest == hz.ID_Rt);
   assign hz.Flush  = bt;
   assign hz.Stall  = !bt && (state == HZ_STALL || hit);
   assign hz.Bubble = bt || hz.Stall;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         ex    <= '0;
         mem   <= '0;
         wb    <= '0;
         state <= HZ_RUN;
         cnt   <= '0;
      end else begin
         ex  <= hz.Bubble ? '0 : {hz.ID_Rs, hz.ID_Rt, hz.ID_Dest, hz.ID_RegWrite, hz.ID_MemRead};
         mem <= ex;
         wb  <= mem;
         if (bt) begin
            state <= HZ_RUN;
            cnt   <= '0;
         end else if (state == HZ_RUN) begin
            if (hit) begin
               cnt   <= CNT_INIT;
               state <= (CNT_INIT != 2'd0) ? HZ_STALL : HZ_RUN;
            end
         end else begin
            cnt   <= cnt - 2'd1;
            state <= (cnt == 2'd1) ? HZ_RUN : HZ_STALL;
         end
      end
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_count, flush_count;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         stall_count <= stall_count + 32'(hz.Stall);
         flush_count <= flush_count + 32'(hz.Flush);
      end
   assign hz.Stall_Count = stall_count;
   assign hz.Flush_Count = flush_count;
`endif
endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb_forward_hazard_unit: drives one instruction stream into two units
// (1 and 2 load-use bubbles) and checks them against a pipeline model.
module tb_forward_hazard_unit;
   import mips_hazard_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_req = 1'b0;
   logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
   logic id_rw = 1'b0, id_mr = 1'b0, br = 1'b0;
   int checks = 0;
   int fails = 0;
   always #5 clk = ~clk;

   forward_hazard_unit_if if0 ();
   forward_hazard_unit_if if1 ();
   forward_hazard_unit #(.LOAD_USE_BUBBLES(1)) u0 (.clk(clk), .reset(rst_n), .hz(if0));
   forward_hazard_unit #(.LOAD_USE_BUBBLES(2)) u1 (.clk(clk), .reset(rst_n), .hz(if1));

   assign if0.ID_Rs = id_rs;   assign if1.ID_Rs = id_rs;
   assign if0.ID_Rt = id_rt;   assign if1.ID_Rt = id_rt;
   assign if0.ID_Dest = id_dest; assign if1.ID_Dest = id_dest;
   assign if0.ID_RegWrite = id_rw; assign if1.ID_RegWrite = id_rw;
   assign if0.ID_MemRead = id_mr;  assign if1.ID_MemRead = id_mr;
   assign if0.Branch_Taken = br;   assign if1.Branch_Taken = br;

   logic [1:0] fa [2], fb [2];
   logic st [2], bb [2], fl [2];
   assign fa[0] = if0.Forward_A; assign fa[1] = if1.Forward_A;
   assign fb[0] = if0.Forward_B; assign fb[1] = if1.Forward_B;
   assign st[0] = if0.Stall;  assign st[1] = if1.Stall;
   assign bb[0] = if0.Bubble; assign bb[1] = if1.Bubble;
   assign fl[0] = if0.Flush;  assign fl[1] = if1.Flush;
`ifdef HAZARD_STATS_EN
   logic [31:0] sc [2], fc [2];
   assign sc[0] = if0.Stall_Count; assign sc[1] = if1.Stall_Count;
   assign fc[0] = if0.Flush_Count; assign fc[1] = if1.Flush_Count;
   logic [31:0] m_sc [2], m_fc [2];
`endif

   task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s dut%0d: got %0d, expected %0d", nm, d, got, exp);
      end
   endtask

   // model: age 0 = EX, 1 = MEM, 2 = WB; rem = stall cycles still owed
   slot_t ms [2][3];
   int rem [2];

   function automatic logic [1:0] fwd_of(input int d, input logic [4:0] src);
      logic [1:0] r = 2'd0;
      for (int a = 2; a >= 1; a--)
         if (ms[d][a].regwrite && ms[d][a].dest == src && src != 5'd0) r = (a == 1) ? 2'd2 : 2'd1;
      return r;
   endfunction

   always @(negedge clk) begin : model
      logic hit, ef, es, eb;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            for (int a = 0; a < 3; a++) ms[d][a] = '0;
            rem[d] = 0;
`ifdef HAZARD_STATS_EN
            m_sc[d] = 0;
            m_fc[d] = 0;
`endif
         end
         hit = ms[d][0].memread && ms[d][0].dest != 5'd0 &&
               (ms[d][0].dest == id_rs || ms[d][0].dest == id_rt);
         ef = br && rst_n;
         es = !ef && (rem[d] > 0 || hit);
         eb = ef || es;
         chk("model_fwd_a", d, 32'(fa[d]), 32'(fwd_of(d, ms[d][0].rs)));
         chk("model_fwd_b", d, 32'(fb[d]), 32'(fwd_of(d, ms[d][0].rt)));
         chk("model_stall", d, 32'(st[d]), 32'(es));
         chk("model_bubble", d, 32'(bb[d]), 32'(eb));
         chk("model_flush", d, 32'(fl[d]), 32'(ef));
`ifdef HAZARD_STATS_EN
         chk("model_stall_count", d, sc[d], m_sc[d]);
         chk("model_flush_count", d, fc[d], m_fc[d]);
`endif
         if (rst_n) begin
            ms[d][2] = ms[d][1];
            ms[d][1] = ms[d][0];
            ms[d][0] = eb ? '0 : {id_rs, id_rt, id_dest, id_rw, id_mr};
            rem[d] = ef ? 0 : (rem[d] > 0) ? rem[d] - 1 : hit ? d : 0;
`ifdef HAZARD_STATS_EN
            m_sc[d] += 32'(es);
            m_fc[d] += 32'(ef);
`endif
         end
      end
   end

   task automatic cyc(input int rs, input int rt, input int dest, input int rw, input int mr, input int b);
      @(posedge clk);
      #2;
      rst_n = rst_req;
      id_rs = 5'(rs); id_rt = 5'(rt); id_dest = 5'(dest);
      id_rw = 1'(rw); id_mr = 1'(mr); br = 1'(b);
      @(negedge clk);
      #1;
   endtask

   task automatic nops(input int n);
      repeat (n) cyc(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      nops(2);
      for (int d = 0; d < 2; d++) begin
         chk("reset_fwd_a", d, 32'(fa[d]), 0);
         chk("reset_fwd_b", d, 32'(fb[d]), 0);
         chk("reset_stall", d, 32'(st[d]), 0);
         chk("reset_bubble", d, 32'(bb[d]), 0);
         chk("reset_flush", d, 32'(fl[d]), 0);
      end
      rst_req = 1'b1;
      nops(3);
      // add $3 ; sub uses $3 as rs
      cyc(1, 2, 3, 1, 0, 0);
      cyc(3, 4, 7, 1, 0, 0);
      nops(1);
      chk("exmem_fwd_a", 0, 32'(fa[0]), 2);
      chk("exmem_no_stall", 0, 32'(st[0]), 0);
      nops(3);
      // add $5 ; nop ; or uses $5 as rt
      cyc(1, 2, 5, 1, 0, 0);
      nops(1);
      cyc(8, 5, 9, 1, 0, 0);
      nops(1);
      chk("memwb_fwd_b", 0, 32'(fb[0]), 1);
      chk("memwb_fwd_a_idle", 0, 32'(fa[0]), 0);
      nops(3);
      // add $6 ; sub $6 ; and $6,$6
      cyc(1, 2, 6, 1, 0, 0);
      cyc(1, 2, 6, 1, 0, 0);
      cyc(6, 6, 10, 1, 0, 0);
      nops(1);
      chk("prio_fwd_a", 0, 32'(fa[0]), 2);
      chk("prio_fwd_b", 0, 32'(fb[0]), 2);
      nops(3);
      // lw $4 ; add uses $4, held in ID while stalled
      cyc(1, 0, 4, 1, 1, 0);
      cyc(4, 2, 11, 1, 0, 0);
      chk("lu_stall", 0, 32'(st[0]), 1);
      chk("lu_bubble", 0, 32'(bb[0]), 1);
      chk("lu2_stall", 1, 32'(st[1]), 1);
      cyc(4, 2, 11, 1, 0, 0);
      chk("lu_stall_done", 0, 32'(st[0]), 0);
      chk("lu2_stall_second", 1, 32'(st[1]), 1);
      cyc(4, 2, 11, 1, 0, 0);
      chk("lu_fwd_a", 0, 32'(fa[0]), 1);
      chk("lu2_stall_done", 1, 32'(st[1]), 0);
      nops(1);
      chk("lu2_fwd_a", 1, 32'(fa[1]), 0);
      nops(3);
      // lw $0 ; reader of $0
      cyc(1, 2, 0, 1, 1, 0);
      cyc(0, 0, 12, 1, 0, 0);
      chk("zero_no_stall", 0, 32'(st[0]), 0);
      nops(1);
      chk("zero_fwd_a", 0, 32'(fa[0]), 0);
      chk("zero_fwd_b", 0, 32'(fb[0]), 0);
      nops(3);
      // branch taken during a load-use hit
      cyc(1, 0, 4, 1, 1, 0);
      cyc(4, 2, 11, 1, 0, 1);
      chk("br_flush", 0, 32'(fl[0]), 1);
      chk("br_bubble", 0, 32'(bb[0]), 1);
      chk("br_stall", 0, 32'(st[0]), 0);
      chk("br2_stall", 1, 32'(st[1]), 0);
      nops(1);
      chk("br2_after_stall", 1, 32'(st[1]), 0);
      nops(3);
      // reset while the 2-bubble unit sits in STALL
      cyc(1, 0, 4, 1, 1, 0);
      cyc(4, 2, 11, 1, 0, 0);
      chk("rs_pre_stall", 1, 32'(st[1]), 1);
      rst_req = 1'b0;
      cyc(4, 2, 11, 1, 0, 0);
      chk("rs_stall", 1, 32'(st[1]), 0);
      chk("rs_bubble", 1, 32'(bb[1]), 0);
      chk("rs_flush", 1, 32'(fl[1]), 0);
      chk("rs_fwd_a", 1, 32'(fa[1]), 0);
      chk("rs_fwd_b", 1, 32'(fb[1]), 0);
      rst_req = 1'b1;
      cyc(4, 2, 11, 1, 0, 0);
      chk("rs_run_after", 1, 32'(st[1]), 0);
      nops(4);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
